free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter PRF_NUM, default 64: physical register count, power of two; index width `PRF_NUM_WIDTH (6).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 recover  input  1  mispredict/exception flush; restores speculative allocation state to committed state.
REQ-005 alloc_req_0 / alloc_req_1  input  1 each  rename slot 0/1 needs a new destination PRF (valid && rename_en).
REQ-006 prf_new_0 / prf_new_1  output  `PRF_NUM_WIDTH each  new PRF for slot 0/1; feeds map table prf_rd_new.
REQ-007 alloc_ok  output  1  enough free entries for all asserted requests this cycle.
REQ-008 commit_0_valid / commit_1_valid  input  1 each  committing instruction in slot 0/1 renamed a destination.
REQ-009 commit_stale_0 / commit_stale_1  input  `PRF_NUM_WIDTH each  stale PRF released by that commit.
REQ-010 free_count  output  `PRF_NUM_WIDTH+1  current speculative free-entry count.

Function
REQ-011 Storage: circular queue of PRF_NUM entries; spec head, committed head and tail pointers each `PRF_NUM_WIDTH+1 bits (wrap bit); index = low bits; wrap-around natural modulo PRF_NUM.
REQ-012 free_count = tail - spec_head (unsigned, wrap-bit arithmetic); 0..PRF_NUM.
REQ-013 need = alloc_req_0 + alloc_req_1; alloc_ok = (free_count >= need); alloc_ok = 1 when need = 0.
REQ-014 prf_new_0 = queue[spec_head]; prf_new_1 = alloc_req_0 ? queue[spec_head+1] : queue[spec_head]; combinational, zero latency.
REQ-015 Allocation all-or-nothing: when alloc_ok && !recover, spec_head advances by need; when !alloc_ok, spec_head holds (upstream stalls both slots).
REQ-016 Frees: each asserted commit_k_valid writes commit_stale_k at tail (slot 0 first, then slot 1); tail advances by count of frees.
REQ-017 Committed head advances by (commit_0_valid + commit_1_valid) every cycle, independent of recover.
REQ-018 No free-to-alloc bypass: an entry freed in cycle N is allocatable from cycle N+1.
REQ-019 Simultaneous alloc and free: both applied; next free_count = free_count - need + frees.
REQ-020 recover: spec_head <= committed head next value (including same-cycle commits); allocations that cycle discarded; same-cycle frees still applied.
REQ-021 rst has priority over recover; recover has priority over allocation.
REQ-022 Overflow (free with free_count = PRF_NUM) is illegal; covered by assertion, behaviour undefined.
REQ-023 PRF 0 never enters the queue and is never produced as prf_new.

Reset
REQ-024 On rst: queue[i] = i+1 for i = 0..PRF_NUM-2; spec_head = committed head = 0; tail = PRF_NUM-1; free_count = PRF_NUM-1 (63); alloc_ok = 1; prf_new_0 = 1, prf_new_1 = 1 (no req) / 2 (req_0).
REQ-025 rst mid-operation discards all pending allocations and frees in that cycle.

Structure
REQ-026 PRF_NUM, `PRF_NUM_WIDTH, `ARF_NUM_WIDTH stay in defines.svh; commit-free struct (stale PRF, valid) joins the shared package beside commit_info.
REQ-027 Single flat module; no sub-module; pointer/count logic in one always block, queue writes in another.

Verification
REQ-028 Reset then req_0=req_1=1 -> prf_new_0=1, prf_new_1=2, alloc_ok=1; next cycle free_count=61, prf_new_0=3.
REQ-029 Only req_1=1 after reset -> prf_new_1=1; next cycle free_count=62.
REQ-030 Allocate until free_count=1, then req_0=req_1=1 -> alloc_ok=0, spec_head holds; req_0 alone -> alloc_ok=1.
REQ-031 free_count=0, commit_0_valid with stale=7 same cycle as req_0 -> alloc_ok=0; next cycle prf_new_0=7, alloc_ok=1.
REQ-032 Allocate 10, commit 2 (stale 40,41), then recover -> free_count = 63-2+2 = 63; next prf_new_0 = 3 (first uncommitted allocation).
REQ-033 Run 200 cycles random alloc/free wrapping pointers past 64 -> free_count always equals model; no PRF duplicated between queue and allocated set.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-stage types and width macros used by the free list and its neighbours.
// The macros are guarded so that a shared defines header may supply them first.
`ifndef PRF_NUM_WIDTH
`define PRF_NUM_WIDTH 6
`endif
`ifndef ARF_NUM_WIDTH
`define ARF_NUM_WIDTH 5
`endif

package free_list_pkg;

   // Stale physical register released by one committing instruction
   typedef struct packed {
      logic [`PRF_NUM_WIDTH-1:0] stale_prf;
      logic                      valid;
   } commit_free_t;

   // Architectural destination and the stale mapping it retires
   typedef struct packed {
      logic [`ARF_NUM_WIDTH-1:0] arf_rd;
      logic [`PRF_NUM_WIDTH-1:0] prf_rd_stale;
      logic                      rd_valid;
   } commit_info_t;

   function automatic logic [1:0] count2(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular queue with speculative head, committed head
// and tail; two allocations and two frees per cycle, flush restores committed head.
module free_list
   import free_list_pkg::*;
#(
   parameter int PRF_NUM = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      recover,
   input  logic                      alloc_req_0,
   input  logic                      alloc_req_1,
   output logic [`PRF_NUM_WIDTH-1:0] prf_new_0,
   output logic [`PRF_NUM_WIDTH-1:0] prf_new_1,
   output logic                      alloc_ok,
   input  logic                      commit_0_valid,
   input  logic                      commit_1_valid,
   input  logic [`PRF_NUM_WIDTH-1:0] commit_stale_0,
   input  logic [`PRF_NUM_WIDTH-1:0] commit_stale_1,
   output logic [`PRF_NUM_WIDTH:0]   free_count
);

   localparam int W = `PRF_NUM_WIDTH;
   typedef logic [W:0] ptr_t;

   logic [W-1:0] queue_r [PRF_NUM];
   ptr_t         spec_head_r;
   ptr_t         commit_head_r;
   ptr_t         tail_r;

   commit_free_t free_0_s;
   commit_free_t free_1_s;
   ptr_t         free_count_s;
   ptr_t         commit_head_nxt_s;
   ptr_t         spec_head_p1_s;
   ptr_t         tail_p1_s;
   logic [1:0]   need_s;
   logic [1:0]   n_free_s;
   logic         alloc_ok_s;

   assign free_0_s = '{stale_prf: commit_stale_0, valid: commit_0_valid};
   assign free_1_s = '{stale_prf: commit_stale_1, valid: commit_1_valid};

   // Occupancy, grant decision and zero-latency read of the next free entries
   always_comb begin
      need_s            = count2(alloc_req_0, alloc_req_1);
      n_free_s          = count2(free_0_s.valid, free_1_s.valid);
      free_count_s      = tail_r - spec_head_r;
      alloc_ok_s        = (free_count_s >= ptr_t'(need_s));
      commit_head_nxt_s = commit_head_r + ptr_t'(n_free_s);
      spec_head_p1_s    = spec_head_r + ptr_t'(1'b1);
      tail_p1_s         = tail_r + ptr_t'(1'b1);
      prf_new_0         = queue_r[spec_head_r[W-1:0]];
      if (alloc_req_0) begin
         prf_new_1 = queue_r[spec_head_p1_s[W-1:0]];
      end else begin
         prf_new_1 = queue_r[spec_head_r[W-1:0]];
      end
   end

   assign alloc_ok   = alloc_ok_s;
   assign free_count = free_count_s;

   // Pointer update; the committed head keeps moving even while flushing
   always_ff @(posedge clk) begin
      if (rst) begin
         spec_head_r   <= '0;
         commit_head_r <= '0;
         tail_r        <= ptr_t'(PRF_NUM - 1);
      end else begin
         commit_head_r <= commit_head_nxt_s;
         tail_r        <= tail_r + ptr_t'(n_free_s);
         if (recover) begin
            spec_head_r <= commit_head_nxt_s;
         end else if (alloc_ok_s) begin
            spec_head_r <= spec_head_r + ptr_t'(need_s);
         end
      end
   end

   // Queue contents: reset fill with 1..PRF_NUM-1, then freed registers appended at tail
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PRF_NUM; i++) begin
            if (i == PRF_NUM - 1) begin
               queue_r[i] <= {W{1'b0}};
            end else begin
               queue_r[i] <= W'(i + 1);
            end
         end
      end else begin
         if (free_0_s.valid) begin
            queue_r[tail_r[W-1:0]] <= free_0_s.stale_prf;
         end
         if (free_1_s.valid) begin
            if (free_0_s.valid) begin
               queue_r[tail_p1_s[W-1:0]] <= free_1_s.stale_prf;
            end else begin
               queue_r[tail_r[W-1:0]] <= free_1_s.stale_prf;
            end
         end
      end
   end

endmodule
